// File: rtl/gru_state_update_if.sv
// Handshake bus between the gate multiply-add stage, the GRU state-update
// block and its downstream consumer. The slave modport is the state-update
// block itself; the master modport is whatever drives and consumes it.
interface gru_state_update_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] z_pre;
   logic signed [DATA_WIDTH-1:0] c_pre;
   logic                         first;
   logic                         out_valid;
   logic                         out_ready;
   logic signed [DATA_WIDTH-1:0] h_out;
   logic signed [DATA_WIDTH-1:0] h_state;
   logic [CNT_WIDTH-1:0]         step_cnt;

   modport master (
      output in_valid, z_pre, c_pre, first, out_ready,
      input  in_ready, out_valid, h_out, h_state, step_cnt
   );

   modport slave (
      input  in_valid, z_pre, c_pre, first, out_ready,
      output in_ready, out_valid, h_out, h_state, step_cnt
   );
endinterface

// File: rtl/gru_state_update.sv
// GRU hidden-state update: hard-sigmoid gate, hard-tanh candidate, then
// h_new = h + z*(c - h). The held h is fed back to the multiply-add stage.
// Optional step counter enabled by defining GRU_STEP_CNT_EN.
module gru_state_update #(
   parameter int DATA_WIDTH  = 8,
   parameter int FRACT_WIDTH = 5,
   parameter int CNT_WIDTH   = 16
) (
   input logic               clk,
   input logic               rst,
   gru_state_update_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int EW = DATA_WIDTH + 2;   // activation arithmetic width
   localparam int DW = DATA_WIDTH + 1;   // difference / blend width
   localparam int PW = EW + DW;          // full product width
   localparam logic signed [EW-1:0] ONE_E  = EW'(1 <<< FRACT_WIDTH);
   localparam logic signed [EW-1:0] HALF_E = EW'(1 <<< (FRACT_WIDTH - 1));

   typedef enum logic [1:0] {IDLE, ACT, MIX, OUT} state_t;
   state_t state, state_nx;

   logic signed [W-1:0]  zp, cp, hw;
   logic signed [EW-1:0] z_r, c_r;
   logic signed [W-1:0]  h_out_r, h_state_r;

   logic signed [EW-1:0] z_ext, zs, z_c, c_ext, c_c;
   logic signed [DW-1:0] d, p, hs;
   logic signed [PW-1:0] prod;
   logic signed [W-1:0]  hn;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state: fixed walk through ACT and MIX, wait in OUT for the consumer
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nx = ACT;
         ACT:                        state_nx = MIX;
         MIX:                        state_nx = OUT;
         OUT:     if (bus.out_ready) state_nx = IDLE;
         default:                    state_nx = IDLE;
      endcase
   end

   // handshake outputs are pure decodes of the state
   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == OUT);
   end

   // hard-sigmoid on the gate, hard-tanh on the candidate
   always_comb begin
      z_ext = EW'(zp);
      zs    = (z_ext >>> 2) + HALF_E;
      z_c   = zs;
      if (zs < 0)          z_c = '0;
      else if (zs > ONE_E) z_c = ONE_E;
      c_ext = EW'(cp);
      c_c   = c_ext;
      if (c_ext < -ONE_E)     c_c = -ONE_E;
      else if (c_ext > ONE_E) c_c = ONE_E;
   end

   // blend; the floor shift keeps z=0 exact and z=ONE lands exactly on c
   always_comb begin
      d    = DW'(c_r) - DW'(hw);
      prod = PW'(z_r) * PW'(d);
      p    = DW'(prod >>> FRACT_WIDTH);
      hs   = DW'(hw) + p;
      if (hs[DW-1] != hs[DW-2])
         hn = hs[DW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
         hn = hs[W-1:0];
   end

   // datapath registers: capture, activate, then commit the new h on OUT entry
   always_ff @(posedge clk) begin
      if (rst) begin
         zp        <= '0;
         cp        <= '0;
         hw        <= '0;
         z_r       <= '0;
         c_r       <= '0;
         h_out_r   <= '0;
         h_state_r <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               zp <= bus.z_pre;
               cp <= bus.c_pre;
               // a new sequence starts from zero, not from the stale state
               hw <= bus.first ? '0 : h_state_r;
            end
            ACT: begin
               z_r <= z_c;
               c_r <= c_c;
            end
            MIX: begin
               h_state_r <= hn;
               h_out_r   <= hn;
            end
            default: ;
         endcase
      end
   end

   assign bus.h_out   = h_out_r;
   assign bus.h_state = h_state_r;

`ifdef GRU_STEP_CNT_EN
   logic                 fst;
   logic [CNT_WIDTH-1:0] cnt;

   // remember whether the transaction in flight opened a sequence
   always_ff @(posedge clk) begin
      if (rst)                                 fst <= 1'b0;
      else if (state == IDLE && bus.in_valid)  fst <= bus.first;
   end

   // count completed updates, restarting at 1 on a sequence start
   always_ff @(posedge clk) begin
      if (rst)               cnt <= '0;
      else if (state == MIX) cnt <= fst ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);
   end

   assign bus.step_cnt = cnt;
`else
   assign bus.step_cnt = '0;
`endif
endmodule
